// File: rtl/signal_decay_sweeper.sv
// Pheromone evaporation sweeper: on each tick, raster-scans the environment grid and
// writes every nonzero signal back reduced by DECAY (floored at zero), yielding to ant updates.
module signal_decay_sweeper #(
  parameter int X_bits      = 8,
  parameter int Y_bits      = 7,
  parameter int X_max       = 160,
  parameter int Y_max       = 120,
  parameter int SIGNAL_bits = 4,
  parameter int DECAY       = 1
) (
  input  logic                   newLocClock,
  input  logic                   RESET_SIM,
  input  logic                   tick,
  input  logic                   enable,
  input  logic                   ant_write_req,
  output logic [X_bits-1:0]      rd_x,
  output logic [Y_bits-1:0]      rd_y,
  input  logic [SIGNAL_bits-1:0] rd_signal,
  output logic [X_bits-1:0]      wr_x,
  output logic [Y_bits-1:0]      wr_y,
  output logic [SIGNAL_bits-1:0] wr_signal,
  output logic                   wr_en,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [15:0]            sweep_count
);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    STREAM,
    REFETCH,
    DONE
  } state_t;

  localparam logic [X_bits-1:0]      X_LAST  = X_bits'(X_max - 1);
  localparam logic [Y_bits-1:0]      Y_LAST  = Y_bits'(Y_max - 1);
  localparam logic [SIGNAL_bits-1:0] DECAY_V = SIGNAL_bits'(DECAY);

  state_t            state_q, state_d;
  logic [X_bits-1:0] rdX_q, rdX_d, wrX_q;
  logic [Y_bits-1:0] rdY_q, rdY_d, wrY_q;
  logic              overrun_q, overrun_d;
  logic [15:0]       count_q, count_d;

  logic                   stall;
  logic                   writeSlot;
  logic                   lastSlot;
  logic [X_bits-1:0]      nextX;
  logic [Y_bits-1:0]      nextY;
  logic [SIGNAL_bits-1:0] decayed;

  assign stall    = ant_write_req | ~enable;
  assign lastSlot = (wrX_q == X_LAST) && (wrY_q == Y_LAST);
  assign decayed  = (rd_signal > DECAY_V) ? (rd_signal - DECAY_V) : '0;

  // Raster successor of the read pointer; parks on the final cell once it gets there.
  always_comb begin
    nextX = rdX_q;
    nextY = rdY_q;
    if (rdX_q != X_LAST) begin
      nextX = rdX_q + 1'b1;
    end else if (rdY_q != Y_LAST) begin
      nextX = '0;
      nextY = rdY_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    rdX_d     = rdX_q;
    rdY_d     = rdY_q;
    overrun_d = overrun_q;
    count_d   = count_q;
    writeSlot = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && enable) begin
          state_d = PRIME;
          rdX_d   = '0;
          rdY_d   = '0;
        end
      end
      PRIME: begin
        if (tick) overrun_d = 1'b1;
        if (!stall) begin
          state_d = STREAM;
          rdX_d   = nextX;
          rdY_d   = nextY;
        end
      end
      STREAM: begin
        if (tick) overrun_d = 1'b1;
        if (stall) begin
          // Drop the pending write and re-read that cell once the ant is finished with it.
          state_d = REFETCH;
          rdX_d   = wrX_q;
          rdY_d   = wrY_q;
        end else begin
          writeSlot = 1'b1;
          if (lastSlot) begin
            state_d = DONE;
          end else begin
            rdX_d = nextX;
            rdY_d = nextY;
          end
        end
      end
      REFETCH: begin
        if (tick) overrun_d = 1'b1;
        if (!stall) begin
          state_d = STREAM;
          rdX_d   = nextX;
          rdY_d   = nextY;
        end
      end
      DONE: begin
        count_d = count_q + 16'd1;
        if (tick && enable) begin
          state_d = PRIME;
          rdX_d   = '0;
          rdY_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge newLocClock) begin
    if (RESET_SIM) begin
      state_q   <= IDLE;
      rdX_q     <= '0;
      rdY_q     <= '0;
      wrX_q     <= '0;
      wrY_q     <= '0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rdX_q     <= rdX_d;
      rdY_q     <= rdY_d;
      wrX_q     <= rdX_q;
      wrY_q     <= rdY_q;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  // Zero cells are left untouched so they never contend with the ant write path.
  assign wr_en       = writeSlot && (rd_signal != '0) && !RESET_SIM;
  assign wr_signal   = writeSlot ? decayed : '0;
  assign rd_x        = rdX_q;
  assign rd_y        = rdY_q;
  assign wr_x        = wrX_q;
  assign wr_y        = wrY_q;
  assign busy        = (state_q == PRIME) || (state_q == STREAM) || (state_q == REFETCH);
  assign done        = (state_q == DONE);
  assign overrun     = overrun_q;
  assign sweep_count = count_q;

endmodule

// File: doc/signal_decay_sweeper.md
# signal_decay_sweeper

Evaporates ant pheromone across the whole grid once per game tick. On each tick it raster-scans every environment cell, reads its signal value, and writes back the value minus a fixed decay, saturating at zero. It sits beside the ant update path on the environment's lookup and write ports. It yields the write port to ant updates whenever they request it.

## Interface

**Parameters**
- `X_bits`, default 8: grid X coordinate width.
- `Y_bits`, default 7: grid Y coordinate width.
- `X_max`, default 160: grid columns; cells 0..X_max-1.
- `Y_max`, default 120: grid rows; cells 0..Y_max-1.
- `SIGNAL_bits`, default 4: signal value width.
- `DECAY`, default 1: amount subtracted per sweep; range 1..2^SIGNAL_bits-1.

**Ports**
- `newLocClock` in 1: the single clock. All logic is on the rising edge.
- `RESET_SIM` in 1: synchronous, active-high reset.
- `tick` in 1: sweep request, a one-cycle pulse already synchronous to `newLocClock`.
- `enable` in 1: simulation running. Low means paused or in setup.
- `ant_write_req` in 1: an ant update owns the environment ports this cycle.
- `rd_x` out X_bits, `rd_y` out Y_bits: lookup address. Data returns on `rd_signal` one cycle later.
- `rd_signal` in SIGNAL_bits: signal at the previous cycle's `rd_x`/`rd_y`.
- `wr_x` out X_bits, `wr_y` out Y_bits, `wr_signal` out SIGNAL_bits, `wr_en` out 1: environment write port.
- `busy` out 1: a sweep is in progress.
- `done` out 1: one-cycle pulse when a sweep completes.
- `overrun` out 1: sticky flag, set when `tick` arrives while `busy`.
- `sweep_count` out 16: number of completed sweeps; wraps at 65535 -> 0.

## Operation

- **States:** IDLE, PRIME, STREAM, REFETCH, DONE.
- **stall** = `ant_write_req` | ~`enable`.
- **IDLE**
  - `tick` & `enable` -> PRIME, read pointer set to (0,0).
  - `tick` & ~`enable` -> ignored, no flag set.
- **PRIME:** presents the read address.
  - ~stall -> STREAM, pointer advances.
  - stall -> stay, address held.
- **STREAM:** each non-stalled cycle does two things:
  - Writes the cell addressed last cycle: `wr_signal` = (`rd_signal` > DECAY) ? `rd_signal` - DECAY : 0.
  - Presents the next read address.
- **Raster order:** x increments first. At x = X_max-1, x wraps to 0 and y increments.
- **Write suppression:** `wr_en` is asserted only when `rd_signal` != 0. Zero cells are not written.
- **Stall in STREAM** -> REFETCH.
  - Pending write is discarded.
  - Read address is held at the pending cell.
- **REFETCH**
  - Remains while stall is high.
  - First cycle with stall low: `wr_en`=0, address still held.
  - Next cycle returns to STREAM and writes that cell using freshly read data, so a value changed by an ant during the stall is never overwritten with stale data.
- **End of sweep:** after the write slot for (X_max-1, Y_max-1) -> DONE.
- **DONE:** lasts one cycle.
  - `done`=1, `busy`=0, `sweep_count`+1.
  - Then -> IDLE.
- **`tick` while `busy`:** `overrun` set; the tick is otherwise ignored. `overrun` clears only on reset.
- **Reset mid-sweep:** returns to IDLE with no further writes, and the next sweep restarts at (0,0).
- **Reset values:**
  - `rd_x`/`rd_y`/`wr_x`/`wr_y`/`wr_signal` = 0.
  - `wr_en` = `busy` = `done` = `overrun` = 0.
  - `sweep_count` = 0.
  - State = IDLE.

## Timing

- `tick` is sampled high at edge T0. Then:
  - `busy`=1 from T0+1.
  - PRIME address (0,0) is presented during T0+1.
- With N = X_max*Y_max and no stalls:
  - Reads are presented during T0+1 .. T0+N.
  - Write slots occur during T0+2 .. T0+N+1.
  - `done`=1 during T0+N+2, with `busy`=0 that cycle.
- `wr_x`/`wr_y` always equal the `rd_x`/`rd_y` of the previous cycle.
- Stall cost: a stall of k cycles during STREAM delays completion by k+1 cycles. A stall during PRIME costs k cycles.
- `tick` sampled during the DONE cycle is accepted as a new sweep, with no overrun. `busy` rises again at the next cycle.
- `sweep_count` is updated on the edge ending DONE, so its new value is visible from the cycle after the `done` pulse.

## Test plan

- **Basic sweep:** X_max=4, Y_max=3, DECAY=1, all cells hold 5, one `tick`.
  - Expect 12 writes of 4 in raster order (0,0),(1,0)..(3,2).
  - `done` at T0+14, `sweep_count`=1.
- **Saturation and suppression:** cells hold 0,1,2,15, DECAY=2.
  - Writes 0,0,13 for the three nonzero cells.
  - No `wr_en` for the zero cell.
- **Stall:** `ant_write_req` high for 3 cycles mid-STREAM at cell (2,1), and the ant writes 9 there during the stall.
  - No `wr_en` during the stall or the following REFETCH cycle.
  - Cell (2,1) is written as 8.
  - `done` arrives 4 cycles late.
- **Pause and overrun:**
  - `enable` low at `tick` -> no sweep.
  - Second `tick` mid-sweep -> `overrun`=1 and only one `done`.
  - `tick` during the DONE cycle -> a new sweep starts immediately.
- **Reset mid-sweep:** `RESET_SIM` at cell (1,2).
  - All outputs 0 the next cycle.
  - A new `tick` restarts at (0,0) with `sweep_count`=0 before completion.
